// File: rtl/cable_pkg.sv
// rtl/cable_pkg.sv - shared memory-request bundle type
// Purpose: {we, addr, wdata} record as carried toward the memory port.
// Ports: none (package).
package cable_pkg;

  import const_pkg::*;

  typedef struct packed {
    logic                 we;
    logic [REG_WIDTH-1:0] addr;
    logic [REG_WIDTH-1:0] wdata;
  } mem_req_t;

endpackage : cable_pkg

// File: rtl/const_pkg.sv
// rtl/const_pkg.sv - shared numeric constants for the memory arbiter
// Purpose: register width and default D-side streak limit.
// Ports: none (package).
package const_pkg;

  localparam int REG_WIDTH        = 32;
  localparam int D_STREAK_MAX_DEF = 4;

endpackage : const_pkg

// File: rtl/enums_pkg.sv
// rtl/enums_pkg.sv - shared enumerations for the memory arbiter
// Purpose: arbiter FSM state type.
// Ports: none (package).
package enums_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_SERVE_I = 2'd1,
    ARB_SERVE_D = 2'd2
  } arb_state_e;

endpackage : enums_pkg

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester (fetch I / data D) single-port memory arbiter
// Purpose: grants one of I/D to a shared memory port, D preferred, with a
//          bounded D streak so a waiting I request is not starved.
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   i_req/i_addr -> i_gnt/i_rvalid/i_rdata                fetch requester
//   d_req/d_we/d_addr/d_wdata -> d_gnt/d_rvalid/d_rdata   data requester
//   mem_req/mem_we/mem_addr/mem_wdata, mem_ack/mem_rdata  memory port
//   busy                              high while a transaction is in flight
module mem_arbiter
  import const_pkg::*;
  import enums_pkg::*;
#(
  parameter int ADDR_W       = REG_WIDTH,
  parameter int DATA_W       = REG_WIDTH,
  parameter int D_STREAK_MAX = D_STREAK_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int SW = (D_STREAK_MAX < 1) ? 1 : $clog2(D_STREAK_MAX + 1);
  localparam logic [SW-1:0] STREAK_CAP = SW'(D_STREAK_MAX);

  arb_state_e        state_q;
  logic [SW-1:0]     streak_q;
  logic              i_gnt_q, d_gnt_q, i_rvalid_q, d_rvalid_q;
  logic              mem_req_q, mem_we_q, busy_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q, i_rdata_q, d_rdata_q;

  // D wins unless I is also waiting and D has used up its streak allowance.
  logic pick_d, pick_i;
  assign pick_d = d_req && !(i_req && (streak_q == STREAK_CAP));
  assign pick_i = i_req && !pick_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB_IDLE;
      streak_q    <= '0;
      i_gnt_q     <= 1'b0;
      d_gnt_q     <= 1'b0;
      i_rvalid_q  <= 1'b0;
      d_rvalid_q  <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      busy_q      <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      // Grant and rvalid are single-cycle pulses.
      i_gnt_q    <= 1'b0;
      d_gnt_q    <= 1'b0;
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      case (state_q)
        ARB_IDLE: begin
          if (pick_d) begin
            state_q     <= ARB_SERVE_D;
            d_gnt_q     <= 1'b1;
            mem_req_q   <= 1'b1;
            busy_q      <= 1'b1;
            mem_we_q    <= d_we;
            mem_addr_q  <= d_addr;
            mem_wdata_q <= d_wdata;
            // Only D grants that make I wait count toward the streak.
            if (!i_req)
              streak_q <= '0;
            else if (streak_q != STREAK_CAP)
              streak_q <= streak_q + 1'b1;
          end else if (pick_i) begin
            state_q     <= ARB_SERVE_I;
            i_gnt_q     <= 1'b1;
            mem_req_q   <= 1'b1;
            busy_q      <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= i_addr;
            mem_wdata_q <= '0;
            streak_q    <= '0;
          end
        end
        ARB_SERVE_I, ARB_SERVE_D: begin
          // mem_* fields are left as-is after the ack; mem_req low marks them idle.
          if (mem_ack) begin
            state_q   <= ARB_IDLE;
            mem_req_q <= 1'b0;
            busy_q    <= 1'b0;
            if (state_q == ARB_SERVE_I) begin
              i_rvalid_q <= 1'b1;
              i_rdata_q  <= mem_rdata;
            end else begin
              d_rvalid_q <= 1'b1;
              d_rdata_q  <= mem_rdata;
            end
          end
        end
        default: begin
          state_q   <= ARB_IDLE;
          mem_req_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign i_gnt     = i_gnt_q;
  assign d_gnt     = d_gnt_q;
  assign i_rvalid  = i_rvalid_q;
  assign d_rvalid  = d_rvalid_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SMAX = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_req = 1'b0, d_req = 1'b0, d_we = 1'b0, mem_ack = 1'b0;
  logic [AW-1:0] i_addr = '0, d_addr = '0;
  logic [DW-1:0] d_wdata = '0, mem_rdata = '0;
  logic          i_gnt, i_rvalid, d_gnt, d_rvalid, mem_req, mem_we, busy;
  logic [DW-1:0] i_rdata, d_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .D_STREAK_MAX(SMAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Transaction-level reference: who owns the port, how many D grants in a
  // row have made I wait, and what each requester should see next.
  bit            m_active = 0;
  bit            m_is_d = 0;
  int            m_streak = 0;
  logic          e_i_gnt = 0, e_d_gnt = 0, e_i_rv = 0, e_d_rv = 0, e_we = 0;
  logic [AW-1:0] e_addr = '0;
  logic [DW-1:0] e_wdata = '0, e_i_rdata = '0, e_d_rdata = '0;
  bit            e_d_rd_ok = 1;

  task automatic model_step();
    e_i_gnt = 0; e_d_gnt = 0; e_i_rv = 0; e_d_rv = 0;
    if (!rst_n) begin
      m_active = 0; m_streak = 0;
      e_i_rdata = '0; e_d_rdata = '0; e_d_rd_ok = 1;
      return;
    end
    if (!m_active) begin
      if (d_req && !(i_req && m_streak == SMAX)) begin
        m_active = 1; m_is_d = 1; e_d_gnt = 1;
        e_we = d_we; e_addr = d_addr; e_wdata = d_wdata;
        m_streak = i_req ? ((m_streak + 1 > SMAX) ? SMAX : m_streak + 1) : 0;
      end else if (i_req) begin
        m_active = 1; m_is_d = 0; e_i_gnt = 1;
        e_we = 0; e_addr = i_addr; e_wdata = '0;
        m_streak = 0;
      end
    end else if (mem_ack) begin
      m_active = 0;
      if (m_is_d) begin
        e_d_rv = 1; e_d_rdata = mem_rdata; e_d_rd_ok = !e_we;
      end else begin
        e_i_rv = 1; e_i_rdata = mem_rdata;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_eq("i_gnt",    64'(i_gnt),    64'(e_i_gnt));
    check_eq("d_gnt",    64'(d_gnt),    64'(e_d_gnt));
    check_eq("i_rvalid", 64'(i_rvalid), 64'(e_i_rv));
    check_eq("d_rvalid", 64'(d_rvalid), 64'(e_d_rv));
    check_eq("mem_req",  64'(mem_req),  64'(m_active));
    check_eq("busy",     64'(busy),     64'(m_active));
    check_eq("i_rdata",  64'(i_rdata),  64'(e_i_rdata));
    if (e_d_rd_ok) check_eq("d_rdata", 64'(d_rdata), 64'(e_d_rdata));
    if (m_active) begin
      check_eq("mem_we",    64'(mem_we),    64'(e_we));
      check_eq("mem_addr",  64'(mem_addr),  64'(e_addr));
      check_eq("mem_wdata", 64'(mem_wdata), 64'(e_wdata));
    end
  endtask

  initial begin
    int ng;
    int lat;

    // Reset state
    cycle(); cycle();
    check_eq("rst_addr", 64'(mem_addr), 64'(0));
    rst_n = 1'b1;

    // Single I read, ack in cycle 3
    i_req = 1; i_addr = 32'h100;
    cycle();
    check_eq("t1_gnt", 64'(i_gnt), 64'(1));
    check_eq("t1_addr", 64'(mem_addr), 64'(32'h100));
    i_req = 0;
    cycle();
    cycle();
    check_eq("t1_addr3", 64'(mem_addr), 64'(32'h100));
    check_eq("t1_we3", 64'(mem_we), 64'(0));
    mem_ack = 1; mem_rdata = 32'hDEADBEEF;
    cycle();
    check_eq("t1_rvalid", 64'(i_rvalid), 64'(1));
    check_eq("t1_rdata", 64'(i_rdata), 64'(32'hDEADBEEF));
    mem_ack = 0;

    // Simultaneous I and D
    i_req = 1; i_addr = 32'h300;
    d_req = 1; d_we = 1; d_addr = 32'h200; d_wdata = 32'h55;
    cycle();
    check_eq("t2_dgnt", 64'(d_gnt), 64'(1));
    check_eq("t2_igntlow", 64'(i_gnt), 64'(0));
    check_eq("t2_wdata", 64'(mem_wdata), 64'(32'h55));
    d_req = 0; mem_ack = 1;
    cycle();
    check_eq("t2_drv", 64'(d_rvalid), 64'(1));
    mem_ack = 0;
    cycle();
    check_eq("t2_igant", 64'(i_gnt), 64'(1));
    i_req = 0; mem_ack = 1;
    cycle();
    mem_ack = 0;

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if (!i_req || i_gnt) begin
        i_req = ($urandom_range(0, 99) < 60); i_addr = $urandom;
      end
      if (!d_req || d_gnt) begin
        d_req = ($urandom_range(0, 99) < 60); d_we = 1'($urandom_range(0, 1));
        d_addr = $urandom; d_wdata = $urandom;
      end
      mem_ack   = mem_req ? ($urandom_range(0, 99) < 40) : ($urandom_range(0, 99) < 10);
      mem_rdata = $urandom;
      cycle();
    end

    // Fairness: both held, immediate ack -> D,D,D,D,I repeating
    i_req = 0; d_req = 0; mem_ack = 0;
    rst_n = 0;
    cycle();
    rst_n = 1;
    i_req = 1; d_req = 1; d_we = 0; i_addr = 32'h10; d_addr = 32'h20;
    ng = 0;
    for (int n = 0; n < 40; n++) begin
      mem_ack = mem_req;
      cycle();
      if (i_gnt || d_gnt) begin
        check_eq("fair_seq", 64'(i_gnt), 64'((ng % 5) == 4));
        ng++;
      end
    end
    check_eq("fair_cnt", 64'(ng), 64'(20));

    // Reset in the middle of a D transaction
    i_req = 0; d_req = 0; mem_ack = 1;
    cycle(); cycle();
    mem_ack = 0;
    d_req = 1; d_we = 1; d_addr = 32'hA0; d_wdata = 32'h77;
    cycle();
    check_eq("t4_gnt", 64'(d_gnt), 64'(1));
    cycle();
    #2 rst_n = 0;
    #1;
    check_eq("t4_memreq", 64'(mem_req), 64'(0));
    check_eq("t4_busy", 64'(busy), 64'(0));
    check_eq("t4_addr", 64'(mem_addr), 64'(0));
    check_eq("t4_wdata", 64'(mem_wdata), 64'(0));
    mem_ack = 1;
    cycle();
    check_eq("t4_norv", 64'(d_rvalid), 64'(0));
    rst_n = 1; mem_ack = 0;
    cycle();
    check_eq("t4_regnt", 64'(d_gnt), 64'(1));
    d_req = 0; mem_ack = 1;
    cycle();

    // Spurious ack while idle, then a read with immediate ack
    cycle(); cycle();
    check_eq("t5_busy", 64'(busy), 64'(0));
    check_eq("t5_rv", 64'({i_rvalid, d_rvalid}), 64'(0));
    d_req = 1; d_we = 0; d_addr = 32'h44; mem_rdata = 32'h1234;
    lat = 0;
    for (int n = 0; n < 10; n++) begin
      cycle();
      lat++;
      if (d_rvalid) break;
      if (d_gnt) d_req = 0;
      mem_ack = mem_req;
    end
    check_eq("t5_lat", 64'(lat), 64'(2));
    check_eq("t5_rdata", 64'(d_rdata), 64'(32'h1234));
    mem_ack = 0;
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_mem_arbiter

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default REG_WIDTH (32): address width.
REQ-002 Parameter DATA_W, default REG_WIDTH (32): data word width.
REQ-003 Parameter D_STREAK_MAX, default 4: maximum consecutive D grants while I waits.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 i_req  in  1  fetch-refill request; held with i_addr until i_gnt.
REQ-007 i_addr  in  ADDR_W  fetch read address.
REQ-008 i_gnt  out  1  one-cycle pulse: I request accepted.
REQ-009 i_rvalid  out  1  one-cycle pulse: i_rdata valid.
REQ-010 i_rdata  out  DATA_W  fetch read data.
REQ-011 d_req  in  1  data-cache request; held with d_we, d_addr and d_wdata until d_gnt.
REQ-012 d_we  in  1  1 = write, 0 = read.
REQ-013 d_addr  in  ADDR_W  data address.
REQ-014 d_wdata  in  DATA_W  write data.
REQ-015 d_gnt  out  1  one-cycle pulse: D request accepted.
REQ-016 d_rvalid  out  1  one-cycle pulse: D complete; d_rdata valid for reads.
REQ-017 d_rdata  out  DATA_W  data read result.
REQ-018 mem_req  out  1  memory transaction active.
REQ-019 mem_we  out  1  write strobe.
REQ-020 mem_addr  out  ADDR_W  memory address.
REQ-021 mem_wdata  out  DATA_W  memory write data.
REQ-022 mem_ack  in  1  memory completes current transaction this cycle.
REQ-023 mem_rdata  in  DATA_W  memory read data, valid with mem_ack.
REQ-024 busy  out  1  high whenever state is not IDLE.

Function
REQ-025 The FSM SHALL have states IDLE, SERVE_I and SERVE_D.
- Transitions: IDLE -> SERVE_x on a winning request; SERVE_x -> IDLE on mem_ack.
REQ-026 Arbitration in IDLE: D wins over I, except when both are requesting and streak == D_STREAK_MAX; I then wins.
REQ-027 streak counter:
- Increments on each D grant made while i_req is high.
- Clears on an I grant, and on a D grant made with i_req low.
- Saturates at D_STREAK_MAX.
REQ-028 On grant, the winner's we/addr/wdata SHALL be latched; I transactions force mem_we=0 and mem_wdata=0.
REQ-029 Timing, with cycle 0 as the IDLE cycle sampling the request:
- Cycle 1: x_gnt pulses and mem_req rises with the latched fields.
- Cycle k >= 1 with mem_ack: transaction ends; FSM returns to IDLE at the next edge.
- Cycle k+1: x_rvalid pulses with mem_rdata registered into x_rdata.
REQ-030 mem_req and the mem_* fields SHALL remain stable from grant until the mem_ack cycle inclusive.
REQ-031 mem_ack in the first SERVE cycle SHALL be accepted (k=1; minimum latency 2 cycles request-to-rvalid).
REQ-032 Back-to-back requests: at least one IDLE cycle between transactions; a request still asserted in that IDLE cycle is arbitrated normally.
REQ-033 mem_ack while in IDLE SHALL be ignored; it produces no rvalid and no state change.
REQ-034 Requests arriving while in a SERVE state SHALL be ignored until IDLE; they are never lost, since requesters hold them.
REQ-035 d_rvalid SHALL pulse for writes as well as reads; d_rdata contents for writes are don't-care.
REQ-036 x_rdata SHALL hold its last value until the next rvalid for that requester.

Reset
REQ-037 Asserting rst_n=0 at any time, including mid-transaction, SHALL asynchronously force:
- state IDLE and streak 0;
- all gnt, rvalid, mem_req, mem_we and busy outputs to 0;
- all data and address outputs to 0.
The in-flight memory transaction is abandoned.
REQ-038 After rst_n deasserts, the first grant SHALL occur no earlier than the first rising edge with rst_n high.

Structure
REQ-039 Shared package contents:
- arb_state_e in enums_pkg.
- mem_req_t {we, addr, wdata} in cable_pkg.
- D_STREAK_MAX default in const_pkg.
REQ-040 The block SHALL be a single module with no sub-modules; the streak counter and FSM are inline.

Verification
REQ-041 Single I read: i_req, i_addr=0x100; mem_ack at cycle 3 with mem_rdata=0xDEADBEEF -> i_gnt at cycle 1, mem_addr=0x100 and mem_we=0 during cycles 1-3, i_rvalid at cycle 4 with i_rdata=0xDEADBEEF.
REQ-042 Simultaneous requests: i_req and d_req (d_we=1, d_addr=0x200, d_wdata=0x55) together -> D granted first, mem_wdata=0x55; I granted after one IDLE cycle.
REQ-043 Fairness: i_req held and d_req held continuously, mem_ack at k=1 -> exactly 4 consecutive d_gnt, then i_gnt, then the streak restarts.
REQ-044 Reset mid-transaction: rst_n=0 during SERVE_D before mem_ack -> mem_req=0, busy=0 and no d_rvalid; after release, the held d_req is re-granted.
REQ-045 Spurious ack: mem_ack=1 in IDLE with no requests -> no rvalid, busy stays 0; then d_req read with immediate ack -> d_rvalid exactly 2 cycles after request.
